// File: rtl/map_pkg.sv
// Shared types and frame sizes for the VGA map BRAM write path.
package map_pkg;

  localparam int unsigned FRAME_WORDS_640x480 = 307200;
  localparam int unsigned FRAME_WORDS_384x288 = 110592;

  typedef enum logic {
    ARB,
    CLEAR
  } state_t;

  typedef enum logic {
    GNT_RF,
    GNT_DP
  } gnt_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-grant pointer moves only on a transfer.
module rr_arbiter2
  import map_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic rf_req,
  input  logic dp_req,
  output logic rf_gnt_c,
  output logic dp_gnt_c
);

  gnt_t last_q;

  // RF wins a contest unless it was the last one served
  always_comb begin
    rf_gnt_c = 1'b0;
    dp_gnt_c = 1'b0;
    if (!hold) begin
      if (rf_req && (!dp_req || last_q == GNT_DP)) begin
        rf_gnt_c = 1'b1;
      end else if (dp_req) begin
        dp_gnt_c = 1'b1;
      end
    end
  end

  // Grants only assert alongside a request, so a grant is a transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= GNT_DP;
    end else if (rf_gnt_c) begin
      last_q <= GNT_RF;
    end else if (dp_gnt_c) begin
      last_q <= GNT_DP;
    end
  end

endmodule

// File: rtl/map_write_arbiter.sv
// Port A owner of the VGA map BRAM: round-robin pixel writes from the
// rangefinder and disparity paths, plus a frame-clear sweep.
module map_write_arbiter
  import map_pkg::*;
#(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_640x480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rf_en,
  input  logic              rf_valid,
  input  logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              rf_ready,
  input  logic              dp_en,
  input  logic              dp_valid,
  input  logic [ADDR_W-1:0] dp_addr,
  input  logic [DATA_W-1:0] dp_data,
  output logic              dp_ready,
  input  logic              clr_start,
  input  logic [ADDR_W-1:0] clr_len,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_en,
  output logic              bram_we,
  output logic [15:0]       drop_cnt
);

  localparam logic [ADDR_W-1:0] FRAME_LIM = ADDR_W'(FRAME_WORDS);
  localparam logic [15:0]       DROP_MAX  = 16'hFFFF;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   din_d;
  logic                en_d, we_d, busy_d, done_d;
  logic [15:0]         drop_d;
  logic                hold_c;
  logic [ADDR_W-1:0]   req_addr_c;
  logic [DATA_W-1:0]   req_data_c;

  // A clear request blocks arbitration in the very cycle it is raised
  assign hold_c = (state_q != ARB) || clr_start;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold_c),
    .rf_req   (rf_en & rf_valid),
    .dp_req   (dp_en & dp_valid),
    .rf_gnt_c (rf_ready),
    .dp_gnt_c (dp_ready)
  );

  assign req_addr_c = dp_ready ? dp_addr : rf_addr;
  assign req_data_c = dp_ready ? dp_data : rf_data;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    val_d   = val_q;
    addr_d  = bram_addr;
    din_d   = bram_din;
    en_d    = 1'b0;
    we_d    = 1'b0;
    busy_d  = clr_busy;
    done_d  = 1'b0;
    drop_d  = drop_cnt;
    case (state_q)
      ARB: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          len_d   = (clr_len > FRAME_LIM) ? FRAME_LIM : clr_len;
          val_d   = clr_value;
          busy_d  = 1'b1;
        end else if (rf_ready || dp_ready) begin
          if (req_addr_c < FRAME_LIM) begin
            addr_d = req_addr_c;
            din_d  = req_data_c;
            en_d   = 1'b1;
            we_d   = 1'b1;
          end else if (drop_cnt != DROP_MAX) begin
            drop_d = drop_cnt + 16'd1;
          end
        end
      end
      CLEAR: begin
        if (len_q != '0) begin
          addr_d = cnt_q;
          din_d  = val_q;
          en_d   = 1'b1;
          we_d   = 1'b1;
          cnt_d  = cnt_q + ADDR_W'(1);
        end
        if (len_q == '0 || cnt_q == len_q - ADDR_W'(1)) begin
          state_d = ARB;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State and registered outputs; reset aborts any sweep without clr_done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB;
      cnt_q     <= '0;
      len_q     <= '0;
      val_q     <= '0;
      bram_addr <= '0;
      bram_din  <= '0;
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      val_q     <= val_d;
      bram_addr <= addr_d;
      bram_din  <= din_d;
      bram_en   <= en_d;
      bram_we   <= we_d;
      clr_busy  <= busy_d;
      clr_done  <= done_d;
      drop_cnt  <= drop_d;
    end
  end

endmodule
